dsp_mult_arbiter: RTL
=====================

Name: dsp_mult_arbiter

Overview:
- Shares one registered DSP48 multiplier among N_REQ requesters.
- Each requester presents an operand pair over a valid/ready handshake. The block grants one requester per cycle, round-robin, and feeds the granted operands into a fixed-latency multiply pipeline.
- Each product is returned on a shared response bus, tagged with the requester index.
- Sits between the user logic and the DSP slice: it is the only block that sequences the shared multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OP_W, 8, operand width in bits (unsigned).
- RES_W, 18, result width; the 2*OP_W product is zero-extended to RES_W; RES_W >= 2*OP_W is required.

Ports:
- clk  in  1  fabric clock (from the global buffer).
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*OP_W  packed factor A; requester i occupies bits [i*OP_W +: OP_W].
- req_b  in  N_REQ*OP_W  packed factor B, same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i].
- pause  in  1  when high, no new grants are issued; in-flight operations still complete.
- rsp_valid  out  1  one-cycle pulse for each completed product.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns rsp_result.
- rsp_result  out  RES_W  zero-extended product a*b.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (async assert, sync release): round-robin pointer=0, all pipeline valid bits=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0. Operations in flight when reset asserts are discarded; no response is ever emitted for them.
- Arbitration:
  - req_ready is combinational from req_valid, pause and the pointer.
  - Grant goes to the first i with req_valid[i]=1, searching upward from pointer with wrap-around.
  - At most one bit of req_ready is high, and only for a requester whose valid is high.
  - pause=1 or no valid forces req_ready=0.
- Pointer update: on a handshake with requester g, the pointer becomes (g+1) mod N_REQ at the next edge. Otherwise it holds.
- Requester rules: a requester keeps req_valid high and operands stable until its handshake. Dropping valid before grant is legal; the request is simply withdrawn.
- Pipeline, throughput one operation per cycle, no response backpressure:
  - Stage 1 (edge after handshake): register operands, id and valid.
  - Stage 2: register product, id and valid. Stage 2 is the DSP product register.
  - Base latency: LAT=2. rsp_valid is high exactly 2 edges after the handshake edge.
  - rsp_id and rsp_result hold their last values while rsp_valid=0.
- Width: the product is an unsigned OP_W x OP_W multiply, zero-extended to RES_W. Overflow is impossible by construction.
- busy = OR of all pipeline valid bits. busy is 0 when idle. It drops the cycle after the last rsp_valid pulse.
- Simultaneous events: pause rising in the same cycle as a pending request suppresses that grant. Responses continue to drain during pause.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,... with no gaps.

Optional Feature:
- Macro DSP_MREG_EN.
- Defined: an extra register is inserted between the operand and product stages (DSP MREG). LAT=3. busy covers three valid bits.
- Undefined: LAT=2 as above.
- Arbitration, handshake and ordering are identical in both builds. Responses always leave in grant order.

Decomposition:
- Package dsp_arb_pkg holds:
  - localparam LAT_BASE=2;
  - a function returning the id width for N_REQ, clamped to minimum 1;
  - a typedef for the pipeline stage record {valid, id, a, b / product}.
- Sub-module rr_arbiter (parameter N): inputs req, en, pointer; outputs one-hot grant and encoded index. Purely combinational.
- The pointer register and the pipeline stay in dsp_mult_arbiter.

Test Plan:
- Single request: requester 2 offers a=200, b=250 with pause=0 -> req_ready[2] high the same cycle; rsp_valid pulses 2 cycles after the handshake (3 with DSP_MREG_EN), rsp_id=2, rsp_result=50000; busy high for those cycles only.
- Round-robin: all 4 requesters valid continuously with a=i+1, b=10 -> grant order 0,1,2,3,0,...; back-to-back responses of 10,20,30,40; no idle cycles.
- Pointer wrap: pointer at 3, only requesters 3 and 0 valid -> grant 3 then 0; pointer ends at 1.
- Pause: pause=1 with requester 1 valid while 2 ops are in flight -> req_ready=0; both in-flight responses are still emitted; after pause falls, requester 1 is granted the next cycle.
- Extremes: a=255, b=255 -> rsp_result=65025 (18'h0FE01); a=0, b=255 -> 0.
- Reset mid-flight: assert rst_n=0 one cycle after a handshake -> rsp_valid, busy and the pointer go to 0 immediately; no response appears after release.

Source files
------------

// File: rtl/dsp_arb_pkg.sv
// -----------------------------------------------------------------------------
// dsp_arb_pkg
// Shared definitions for the shared-DSP multiplier arbiter.
//   LAT_BASE      : operand-to-response latency without the DSP MREG stage
//   DEF_*         : default geometry of dsp_mult_arbiter
//   id_width()    : requester-index width, never narrower than one bit
//   op_stage_t /
//   prod_stage_t  : pipeline stage records at the default geometry
// No ports (package).
// -----------------------------------------------------------------------------
package dsp_arb_pkg;

    localparam int LAT_BASE  = 2;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_OP_W  = 8;
    localparam int DEF_RES_W = 18;

    // Index width for n requesters; a single requester still needs one id bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_N_REQ);

    // Operand stage record: {valid, id, a, b}.
    typedef struct packed {
        logic                valid;
        logic [DEF_ID_W-1:0] id;
        logic [DEF_OP_W-1:0] a;
        logic [DEF_OP_W-1:0] b;
    } op_stage_t;

    // Product stage record: {valid, id, product}.
    typedef struct packed {
        logic                 valid;
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_RES_W-1:0] prod;
    } prod_stage_t;

endpackage

// File: rtl/dsp_mult_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first requester at or above
// the pointer (with wrap-around) whose request is high, if enabled.
// Ports:
//   req     in  N   request vector
//   en      in  1   enable; low forces no grant
//   pointer in  IW  highest-priority index (always < N)
//   grant   out N   one-hot grant (all zero if none)
//   idx     out IW  encoded index of the granted requester (0 if none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import dsp_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            // pointer + k is below 2N, so one conditional subtract wraps it.
            sum_s = {1'b0, pointer} + (IW+1)'(k);
            if (sum_s >= (IW+1)'(N)) begin
                sum_s = sum_s - (IW+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IW-1:0];
            if (en && !found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/dsp_mult_arbiter.sv
// -----------------------------------------------------------------------------
// dsp_mult_arbiter
// Shares one registered multiplier among N_REQ requesters. One requester is
// granted per cycle (round-robin); its operands enter a fixed-latency
// multiply pipeline and the zero-extended product returns tagged with the
// requester index. Responses leave in grant order with no backpressure.
// Build option: define DSP_MREG_EN to insert the DSP MREG stage (latency 3
// instead of 2).
// Ports:
//   clk        in  1            fabric clock
//   rst_n      in  1            asynchronous active-low reset
//   req_valid  in  N_REQ        per-requester request valid
//   req_a      in  N_REQ*OP_W   packed factor A, requester i at [i*OP_W +: OP_W]
//   req_b      in  N_REQ*OP_W   packed factor B, same packing
//   req_ready  out N_REQ        one-hot grant (combinational)
//   pause      in  1            blocks new grants; in-flight work drains
//   rsp_valid  out 1            one-cycle pulse per completed product
//   rsp_id     out ID_W         owner of rsp_result
//   rsp_result out RES_W        zero-extended product, held between pulses
//   busy       out 1            any operation in flight
// -----------------------------------------------------------------------------
module dsp_mult_arbiter
    import dsp_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int OP_W  = DEF_OP_W,
    parameter  int RES_W = DEF_RES_W,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  pause,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [RES_W-1:0]      rsp_result,
    output logic                  busy
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_rec_t;

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [RES_W-1:0] prod;
    } prod_rec_t;

    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   ptr_next_s;
    logic [N_REQ-1:0]  grant_s;
    logic [ID_W-1:0]   gidx_s;
    logic              arb_en_s;
    logic              hs_s;
    logic [2*OP_W-1:0] prod_s;
    logic [RES_W-1:0]  prod_ext_s;
    op_rec_t           s1_r;
    prod_rec_t         pre_s;
    prod_rec_t         out_r;

    assign arb_en_s = ~pause;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .en      (arb_en_s),
        .pointer (ptr_r),
        .grant   (grant_s),
        .idx     (gidx_s)
    );

    // The arbiter only grants valid requesters, so any grant is a handshake.
    assign req_ready  = grant_s;
    assign hs_s       = |grant_s;
    assign ptr_next_s = (gidx_s == ID_W'(N_REQ - 1)) ? '0 : gidx_s + ID_W'(1);

    // Round-robin pointer: moves past the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Operand stage: capture the granted requester's operands and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
        end else begin
            s1_r.valid <= hs_s;
            if (hs_s) begin
                s1_r.id <= gidx_s;
                s1_r.a  <= req_a[gidx_s*OP_W +: OP_W];
                s1_r.b  <= req_b[gidx_s*OP_W +: OP_W];
            end else begin
                s1_r.id <= s1_r.id;
                s1_r.a  <= s1_r.a;
                s1_r.b  <= s1_r.b;
            end
        end
    end

    // Full-width unsigned product; RES_W >= 2*OP_W so the cast only zero-extends.
    assign prod_s     = (2*OP_W)'(s1_r.a) * (2*OP_W)'(s1_r.b);
    assign prod_ext_s = RES_W'(prod_s);

`ifdef DSP_MREG_EN
    prod_rec_t m_r;

    // DSP MREG stage between the operand and product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r <= '0;
        end else begin
            m_r.valid <= s1_r.valid;
            if (s1_r.valid) begin
                m_r.id   <= s1_r.id;
                m_r.prod <= prod_ext_s;
            end else begin
                m_r.id   <= m_r.id;
                m_r.prod <= m_r.prod;
            end
        end
    end

    assign pre_s = m_r;
    assign busy  = s1_r.valid | m_r.valid | out_r.valid;
`else
    assign pre_s = '{valid: s1_r.valid, id: s1_r.id, prod: prod_ext_s};
    assign busy  = s1_r.valid | out_r.valid;
`endif

    // Product/response register; id and result only load on a valid op so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
        end else begin
            out_r.valid <= pre_s.valid;
            if (pre_s.valid) begin
                out_r.id   <= pre_s.id;
                out_r.prod <= pre_s.prod;
            end else begin
                out_r.id   <= out_r.id;
                out_r.prod <= out_r.prod;
            end
        end
    end

    assign rsp_valid  = out_r.valid;
    assign rsp_id     = out_r.id;
    assign rsp_result = out_r.prod;

endmodule
